uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmit serializer and its baud-rate timing among `NREQ` requesters. It arbitrates round-robin, latches the winner's byte and the baud selection, and generates the per-bit timing internally. It then drives an 8N1 frame on `tx`. The block sits between the on-chip byte producers and the single UART TX pin.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `DIV0`, 20833, clocks per bit for `baud_sel`=00 (2400 Bd at 50 MHz)
- `DIV1`, 10417, clocks per bit for `baud_sel`=01 (4800 Bd)
- `DIV2`, 5208, clocks per bit for `baud_sel`=10 (9600 Bd)
- `DIV3`, 2604, clocks per bit for `baud_sel`=11 (19200 Bd)

Ports:
- `clk` in 1: single clock; all logic is on its rising edge
- `reset` in 1: synchronous, active-low
- `baud_sel` in 2: rate select, sampled only at grant
- `req` in NREQ: request level per requester
- `data` in 8*NREQ: byte of requester i on `data[8i+7:8i]`
- `gnt` out NREQ: one-hot, one-cycle pulse, marks capture of the requester's byte
- `busy` out 1: high from the grant cycle through the end of the stop bit
- `done` out 1: one-cycle pulse at the end of the stop bit
- `tx` out 1: serial line, idle high

## Operation
- Reset values (`reset`=0 at an edge): `tx`=1, `gnt`=0, `busy`=0, `done`=0, FSM=IDLE, round-robin pointer=0, bit counter=0, divider=0.
- FSM states are IDLE, START, DATA, STOP.
- **IDLE**
  - If `req`≠0, grant the first set request searching upward from the pointer, wrapping modulo NREQ.
  - In the grant cycle: assert the `gnt` bit, latch the byte into the shift register, latch the divisor selected by `baud_sel`, set `busy`, and go to START.
  - Set the pointer to (granted index + 1) mod NREQ.
- **START**: `tx`=0 for DIV cycles, then go to DATA.
- **DATA**
  - `tx` = shift register bit 0; each bit is held for DIV cycles, then shifted right.
  - A 3-bit counter counts 8 bits, LSB first; after bit 7, go to STOP.
- **STOP**: `tx`=1 for DIV cycles. On the last cycle, pulse `done`, clear `busy`, and return to IDLE.
- Divider: counts 0..DIV−1 and wraps. It is cleared on the grant and on every bit boundary. Width is 15 bits, enough for DIV ≤ 32767.
- Boundary behaviour:
  - `req` dropped after grant: the frame completes with the latched byte.
  - `req` still high after `done`: eligible again, subject to the pointer.
  - Requests arriving mid-frame: wait. `gnt` is never asserted while `busy`.
  - `baud_sel` or `data` change mid-frame: ignored until the next grant.
  - A single requester held high continuously: it is re-granted every frame.
  - Reset mid-frame: at that edge `tx`=1 and `busy`=0; no `done` is issued.

## Timing
- Grant latency: `gnt` is asserted in the first cycle `req` is seen in IDLE, i.e. combinationally decoded and registered on that edge. `tx` falls on the edge that registers `gnt`.
- Frame length: 10×DIV cycles from the `tx` fall to `done`, inclusive of the stop bit.
- Back-to-back: the next grant can occur 1 cycle after `done`, so the minimum idle gap is 1 cycle.
- `gnt`, `done` and `tx` are all registered outputs; none is combinational from inputs.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum.
  - Baud-select codes (`BAUD2400`=0, `BAUD4800`=1, `BAUD9600`=2, `BAUD19200`=3).
  - Frame constants: `DATA_BITS`=8, stop bits=1.
- Sub-module `rr_arbiter`: combinational round-robin pick from `req` and pointer, outputting a one-hot grant and an index.
- The top level holds the FSM, divider, shift register and pointer.

## Test plan
Bench uses DIV0..DIV3 = 4, 8, 16, 32.
- **Reset**: hold `reset`=0 for 3 cycles while `req`=4'b1111. Required: `tx`=1, `gnt`=0, `busy`=0, `done`=0 throughout.
- **Single frame**: `baud_sel`=10, `req`=4'b0010, `data[15:8]`=8'hA5. Required:
  - `gnt`=4'b0010 for one cycle.
  - `tx` = 0, 1,0,1,0,0,1,0,1, 1, each held 16 cycles.
  - `done` pulses 160 cycles after the `tx` fall.
- **Round-robin**: `req`=4'b1111 held with distinct bytes. Required: grant order 0,1,2,3,0; each frame's bytes match the granted requester.
- **Mid-frame changes**: change `baud_sel` 00→11 and `data` during DATA. Required: the frame keeps 4-cycle bits and the original byte; the next frame uses 32-cycle bits.
- **Reset mid-frame**: assert `reset` during bit 3. Required: `tx`=1 and `busy`=0 on the next edge, no `done`. After release, with `req`=4'b0001, the first grant is to requester 0.
- **Back-to-back**: `req`=4'b0100 held. Required: the second `gnt` occurs exactly 1 cycle after the first `done`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the shared UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [1:0] BAUD2400  = 2'd0;
  localparam logic [1:0] BAUD4800  = 2'd1;
  localparam logic [1:0] BAUD9600  = 2'd2;
  localparam logic [1:0] BAUD19200 = 2'd3;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int DIV_W     = 15;

  // Maps a baud-select code onto its clocks-per-bit divisor.
  function automatic logic [DIV_W-1:0] pick_div(input logic [1:0] sel,
                                                input int d0, input int d1,
                                                input int d2, input int d3);
    logic [DIV_W-1:0] div;
    div = DIV_W'(d3);
    case (sel)
      BAUD2400:  div = DIV_W'(d0);
      BAUD4800:  div = DIV_W'(d1);
      BAUD9600:  div = DIV_W'(d2);
      BAUD19200: div = DIV_W'(d3);
      default:   div = DIV_W'(d3);
    endcase
    return div;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the
// pointer, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  logic [PW:0] cand;

  // Walk the requesters starting at the pointer and keep the first hit.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!valid && req[cand[PW-1:0]]) begin
        valid               = 1'b1;
        gnt[cand[PW-1:0]]   = 1'b1;
        idx                 = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// One 8N1 UART transmitter shared round-robin among NREQ byte producers.
// The winner's byte and baud divisor are latched at grant; the frame then
// runs to completion regardless of later input changes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DIV0 = 20833,
  parameter int DIV1 = 10417,
  parameter int DIV2 = 5208,
  parameter int DIV3 = 2604,
  localparam int PW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        baud_sel,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic              tx
);

  state_t                 state, state_next;
  logic [DIV_W-1:0]       div_cnt, div_lat;
  logic [2:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic [PW-1:0]          ptr;

  logic [NREQ-1:0]        pick_gnt;
  logic [PW-1:0]          pick_idx;
  logic                   pick_valid;
  logic [7:0]             pick_byte;

  logic                   bit_end, last_bit;
  logic                   tx_next, busy_next, done_next;
  logic [NREQ-1:0]        gnt_next;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign bit_end  = (div_cnt == div_lat - DIV_W'(1));
  assign last_bit = (bit_cnt == 3'(DATA_BITS - 1));

  // Select the byte belonging to the requester the arbiter picked.
  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) pick_byte = pick_byte | data[i*8 +: 8];
    end
  end

  // State register; reset forces IDLE, abandoning any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode: each non-idle state lasts until the divider wraps.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (pick_valid) state_next = START;
      START: if (bit_end) state_next = DATA;
      DATA:  if (bit_end && last_bit) state_next = STOP;
      STOP:  if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs, so tx/gnt/done never glitch.
  always_comb begin
    tx_next   = tx;
    gnt_next  = '0;
    busy_next = busy;
    done_next = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (pick_valid) begin
          gnt_next  = pick_gnt;
          busy_next = 1'b1;
          tx_next   = 1'b0;
        end
      end
      START: if (bit_end) tx_next = shreg[0];
      DATA:  if (bit_end) tx_next = last_bit ? 1'b1 : shreg[1];
      STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          done_next = 1'b1;
          busy_next = 1'b0;
        end
      end
      default: tx_next = 1'b1;
    endcase
  end

  // Datapath: output registers, divider, bit counter, shifter and pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx      <= 1'b1;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      div_cnt <= '0;
      div_lat <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
    end else begin
      tx   <= tx_next;
      gnt  <= gnt_next;
      busy <= busy_next;
      done <= done_next;
      if (state == IDLE) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        if (pick_valid) begin
          shreg   <= pick_byte;
          div_lat <= pick_div(baud_sel, DIV0, DIV1, DIV2, DIV3);
          ptr     <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
        end
      end else if (bit_end) begin
        div_cnt <= '0;
        if (state == DATA) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of single-frame vectors plus hand-written
// sequences for held requests, mid-frame changes and reset mid-frame. A
// monitor decodes every granted frame against a queue of expected frames.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  baud_sel = 2'd0;
  logic [3:0]  req = 4'd0;
  logic [31:0] data = 32'd0;
  logic [3:0]  gnt;
  logic        busy, done, tx;

  uart_tx_arbiter #(.NREQ(NREQ), .DIV0(4), .DIV1(8), .DIV2(16), .DIV3(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .baud_sel (baud_sel),
    .req      (req),
    .data     (data),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] val;
    int         div;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  baud;
    logic [31:0] data;
    int          exp_idx;
    logic [7:0]  exp_byte;
    int          exp_div;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   gnt_cycles[$];
  int   done_cycles[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_seen = 0;
  int frames_done = 0;
  bit mon_en = 1'b0;

  // Free-running cycle count used to measure gaps between frames.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushExp(input int idx, input logic [7:0] val, input int div);
    exp_t e;
    e.idx = idx;
    e.val = val;
    e.div = div;
    sb.push_back(e);
  endtask

  // Checks one frame starting at the negedge where gnt is seen: the grant,
  // the first and last cycle of every bit on tx, and the done pulse timing.
  task automatic checkFrame();
    exp_t       e;
    logic [9:0] bits;
    int         n;
    gnt_seen++;
    gnt_cycles.push_back(cyc);
    if (sb.size() == 0) begin
      checkOutput("unexpected_gnt", gnt, 0);
      return;
    end
    e = sb.pop_front();
    checkOutput("gnt_onehot", gnt, 32'd1 << e.idx);
    checkOutput("busy_at_gnt", busy, 1);
    bits = {1'b1, e.val, 1'b0};
    n = 10 * e.div;
    for (int j = 0; j <= n; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 1) checkOutput("gnt_pulse", gnt, 0);
      if (j < n && ((j % e.div) == 0 || (j % e.div) == e.div - 1))
        checkOutput($sformatf("tx_bit%0d_c%0d", j / e.div, j % e.div), tx, bits[j / e.div]);
      if (j == n - 1) checkOutput("done_early", done, 0);
    end
    checkOutput("done_pulse", done, 1);
    checkOutput("busy_clear", busy, 0);
    done_cycles.push_back(cyc);
    frames_done++;
  endtask

  // Monitor: every grant starts a frame check while enabled.
  always @(negedge clk) begin
    if (mon_en && gnt != 4'd0) checkFrame();
  end

  task automatic waitGnts(input int target, input int budget);
    int k = 0;
    while (gnt_seen < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput("gnt_wait", gnt_seen, target);
  endtask

  task automatic waitFrames(input int target, input int budget);
    int k = 0;
    while (frames_done < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput("frame_wait", frames_done, target);
  endtask

  // Drives one vector, drops req right after the grant, waits for the frame.
  task automatic applyStimulus(input vec_t v);
    int gt, ft;
    gt = gnt_seen + 1;
    ft = frames_done + 1;
    baud_sel = v.baud;
    data     = v.data;
    pushExp(v.exp_idx, v.exp_byte, v.exp_div);
    req = v.req;
    waitGnts(gt, 50);
    req = 4'd0;
    waitFrames(ft, 10 * v.exp_div + 50);
  endtask

  // Last-resort guard so the run always ends with a summary.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int gb, fb, k;
    vec_t v;

    // Pointer starts at 0; each entry's expected winner follows from the
    // pointer left behind by the entry before it.
    vecs[0] = '{4'b0010, 2'd2, 32'h0000A500, 1, 8'hA5, 16};
    vecs[1] = '{4'b0001, 2'd0, 32'h0000003C, 0, 8'h3C, 4};
    vecs[2] = '{4'b1001, 2'd1, 32'hC3000011, 3, 8'hC3, 8};
    vecs[3] = '{4'b1001, 2'd0, 32'h7700005A, 0, 8'h5A, 4};
    vecs[4] = '{4'b0100, 2'd3, 32'h00FF0000, 2, 8'hFF, 32};
    vecs[5] = '{4'b0011, 2'd0, 32'h00008100, 0, 8'h00, 4};
    vecs[6] = '{4'b0010, 2'd0, 32'h00006E00, 1, 8'h6E, 4};
    vecs[7] = '{4'b1000, 2'd1, 32'hB7000000, 3, 8'hB7, 8};

    // Reset held with every requester asking.
    reset = 1'b0;
    req   = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_tx", tx, 1);
      checkOutput("rst_gnt", gnt, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
    end
    req    = 4'd0;
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    #1;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Round-robin with all requesters held; pointer is back at 0.
    $display("[TB] round-robin");
    gb = gnt_seen;
    fb = frames_done;
    baud_sel = 2'd0;
    data     = 32'h43322110;
    pushExp(0, 8'h10, 4);
    pushExp(1, 8'h21, 4);
    pushExp(2, 8'h32, 4);
    pushExp(3, 8'h43, 4);
    pushExp(0, 8'h10, 4);
    req = 4'b1111;
    waitGnts(gb + 5, 300);
    req = 4'd0;
    waitFrames(fb + 5, 100);

    // Mid-frame baud/data change: current frame unaffected, next uses them.
    $display("[TB] mid-frame changes");
    gb = gnt_seen;
    fb = frames_done;
    baud_sel = 2'd0;
    data     = 32'h00000096;
    pushExp(0, 8'h96, 4);
    req = 4'b0001;
    waitGnts(gb + 1, 50);
    repeat (12) @(negedge clk);
    baud_sel = 2'd3;
    data     = 32'h000000E7;
    pushExp(0, 8'hE7, 32);
    waitGnts(gb + 2, 100);
    req = 4'd0;
    waitFrames(fb + 2, 400);

    // Back-to-back frames for a single held requester.
    $display("[TB] back-to-back");
    gb = gnt_seen;
    fb = frames_done;
    baud_sel = 2'd0;
    data     = 32'h005C0000;
    pushExp(2, 8'h5C, 4);
    pushExp(2, 8'h5C, 4);
    req = 4'b0100;
    waitGnts(gb + 2, 100);
    req = 4'd0;
    waitFrames(fb + 2, 100);
    k = gnt_cycles.size() - 1;
    checkOutput("b2b_gap", gnt_cycles[k] - done_cycles[k-1], 1);

    // Reset during data bit 3 (a 0 for A3), checked by hand.
    $display("[TB] reset mid-frame");
    mon_en   = 1'b0;
    baud_sel = 2'd0;
    data     = 32'h0000A300;
    req      = 4'b0010;
    k = 0;
    while (gnt == 4'd0 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput("mrst_gnt", gnt, 4'b0010);
    req = 4'd0;
    repeat (17) @(negedge clk);
    checkOutput("mrst_bit3", tx, 0);
    checkOutput("mrst_busy_before", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mrst_tx", tx, 1);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_done", done, 0);
    checkOutput("mrst_gnt_low", gnt, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("mrst_no_done", done, 0);
      checkOutput("mrst_idle_tx", tx, 1);
    end
    // Pointer must be 0 again, so requester 1 beats requester 2.
    mon_en = 1'b1;
    #1;
    v = '{4'b0110, 2'd0, 32'h00994D00, 1, 8'h4D, 4};
    applyStimulus(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
